// File: rtl/pipeline_hazard_controller_pkg.sv
// rtl/pipeline_hazard_controller_pkg.sv - shared FSM encoding and constants for the hazard controller
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MD_WAIT   = 2'd1,
    EXC_DRAIN = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;
  localparam logic [4:0]  REG_ZERO       = 5'd0;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// rtl/pipeline_hazard_controller_if.sv - pipeline-to-hazard-controller signal bundle
// Optional HAZ_PERF_CNT_EN adds the STALL_CNT/FLUSH_CNT performance outputs.
interface pipeline_hazard_controller_if #(
  parameter int WIDTH_5  = 5,
  parameter int WIDTH_32 = 32
);
  logic [WIDTH_5-1:0]  RS_D;
  logic [WIDTH_5-1:0]  RT_D;
  logic [WIDTH_5-1:0]  RT_E;
  logic [WIDTH_5-1:0]  WRITE_REG_E;
  logic                MEM_TO_REG_E;
  logic                REG_WRITE_E;
  logic                BRANCH_D;
  logic                BRANCH_TAKEN_D;
  logic                MD_START_D;
  logic                MFHILO_D;
  logic                EXC_REQ_M;
  logic [WIDTH_32-1:0] EPC_M;
  logic                PC_EN;
  logic                EN_FD;
  logic                CLR_FD;
  logic                CLR_DE;
  logic                CLR_EM;
  logic                PC_SEL_EXC;
  logic [WIDTH_32-1:0] EXC_PC;
  logic [WIDTH_32-1:0] EPC;
  logic                MD_BUSY;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]         STALL_CNT;
  logic [31:0]         FLUSH_CNT;
`endif

  // master: the datapath driving stage information
  modport master (
    output RS_D, RT_D, RT_E, WRITE_REG_E, MEM_TO_REG_E, REG_WRITE_E,
           BRANCH_D, BRANCH_TAKEN_D, MD_START_D, MFHILO_D, EXC_REQ_M, EPC_M,
    input  PC_EN, EN_FD, CLR_FD, CLR_DE, CLR_EM, PC_SEL_EXC, EXC_PC, EPC, MD_BUSY
`ifdef HAZ_PERF_CNT_EN
    , input STALL_CNT, FLUSH_CNT
`endif
  );

  // slave: the hazard controller
  modport slave (
    input  RS_D, RT_D, RT_E, WRITE_REG_E, MEM_TO_REG_E, REG_WRITE_E,
           BRANCH_D, BRANCH_TAKEN_D, MD_START_D, MFHILO_D, EXC_REQ_M, EPC_M,
    output PC_EN, EN_FD, CLR_FD, CLR_DE, CLR_EM, PC_SEL_EXC, EXC_PC, EPC, MD_BUSY
`ifdef HAZ_PERF_CNT_EN
    , output STALL_CNT, FLUSH_CNT
`endif
  );
endinterface

// File: rtl/pipeline_hazard_controller_md_busy_counter.sv
// rtl/pipeline_hazard_controller_md_busy_counter.sv - mul/div busy-cycle counter with load/abort
module md_busy_counter #(
  parameter int MD_LAT = 4,
  localparam int CNT_W = $clog2(MD_LAT) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic abort_i,
  output logic done_o,
  output logic busy_o
);
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             busy_q, busy_d;

  // abort wins over load so an exception always cancels the unit
  always_comb begin
    md_cnt_d = md_cnt_q;
    busy_d   = busy_q;
    if (abort_i) begin
      md_cnt_d = '0;
      busy_d   = 1'b0;
    end else if (load_i) begin
      md_cnt_d = CNT_W'(MD_LAT - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (md_cnt_q == '0) busy_d = 1'b0;
      else md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_cnt_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      md_cnt_q <= md_cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign done_o = busy_q && (md_cnt_q == '0);
  assign busy_o = busy_q;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - load-use/branch/mul-div stall and exception flush control
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int                   WIDTH_5    = 5,
  parameter int                   WIDTH_32   = 32,
  parameter int                   MD_LAT     = 4,
  parameter logic [WIDTH_32-1:0]  EXC_VECTOR = WIDTH_32'(EXC_VECTOR_DEF)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipeline_hazard_controller_if.slave   bus
);
  localparam logic [WIDTH_5-1:0] ZERO = WIDTH_5'(REG_ZERO);

  ctrl_state_e         state_q, state_d;
  logic [WIDTH_32-1:0] epc_q, epc_d;
  logic lw_haz, br_haz, md_haz, stall, exc_take, br_flush;
  logic md_load, md_done, md_busy;
  logic pc_en, en_fd, clr_fd, clr_de, clr_em, pc_sel;

  assign lw_haz = bus.MEM_TO_REG_E && (bus.RT_E != ZERO) &&
                  ((bus.RT_E == bus.RS_D) || (bus.RT_E == bus.RT_D));
  assign br_haz = bus.BRANCH_D && bus.REG_WRITE_E && (bus.WRITE_REG_E != ZERO) &&
                  ((bus.WRITE_REG_E == bus.RS_D) || (bus.WRITE_REG_E == bus.RT_D));
  assign md_haz = (state_q == MD_WAIT) && (bus.MFHILO_D || bus.MD_START_D);
  assign stall  = lw_haz || br_haz || md_haz;

  // the drain cycle ignores a second exception from the flushed slot
  assign exc_take = rst_n && bus.EXC_REQ_M && (state_q != EXC_DRAIN);
  assign br_flush = rst_n && !exc_take && !stall && bus.BRANCH_D && bus.BRANCH_TAKEN_D;
  assign md_load  = rst_n && (state_q == RUN) && bus.MD_START_D && !stall && !exc_take;

  md_busy_counter #(.MD_LAT(MD_LAT)) u_md_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (md_load),
    .abort_i (exc_take),
    .done_o  (md_done),
    .busy_o  (md_busy)
  );

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    pc_en   = 1'b1;
    en_fd   = 1'b1;
    clr_fd  = 1'b0;
    clr_de  = 1'b0;
    clr_em  = 1'b0;
    pc_sel  = 1'b0;
    if (rst_n) begin
      if (exc_take) begin
        clr_fd = 1'b1;
        clr_de = 1'b1;
        clr_em = 1'b1;
        pc_sel = 1'b1;
      end else if (stall) begin
        pc_en  = 1'b0;
        en_fd  = 1'b0;
        clr_de = 1'b1;
      end else if (br_flush) begin
        clr_fd = 1'b1;
      end
      case (state_q)
        RUN:       if (exc_take) state_d = EXC_DRAIN;
                   else if (md_load) state_d = MD_WAIT;
        MD_WAIT:   if (exc_take) state_d = EXC_DRAIN;
                   else if (md_done) state_d = RUN;
        EXC_DRAIN: state_d = RUN;
        default:   state_d = RUN;
      endcase
      if (exc_take) epc_d = bus.EPC_M;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  assign bus.PC_EN      = pc_en;
  assign bus.EN_FD      = en_fd;
  assign bus.CLR_FD     = clr_fd;
  assign bus.CLR_DE     = clr_de;
  assign bus.CLR_EM     = clr_em;
  assign bus.PC_SEL_EXC = pc_sel;
  assign bus.EXC_PC     = EXC_VECTOR;
  assign bus.EPC        = epc_q;
  assign bus.MD_BUSY    = rst_n && md_busy;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !exc_take && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((exc_take || br_flush) && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.STALL_CNT = stall_cnt_q;
  assign bus.FLUSH_CNT = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;
  // control vector: {PC_EN, EN_FD, CLR_FD, CLR_DE, CLR_EM, PC_SEL_EXC, MD_BUSY}
  localparam logic [6:0] C_N  = 7'b1100000;
  localparam logic [6:0] C_S  = 7'b0001000;
  localparam logic [6:0] C_B  = 7'b1110000;
  localparam logic [6:0] C_X  = 7'b1111110;
  localparam logic [6:0] C_NB = 7'b1100001;
  localparam logic [6:0] C_SB = 7'b0001001;
  localparam logic [6:0] C_XB = 7'b1111111;

  typedef struct {
    string       tag;
    logic [6:0]  ctrl;
    logic [31:0] epc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  pipeline_hazard_controller_if #(.WIDTH_5(5), .WIDTH_32(32)) bus ();

  pipeline_hazard_controller #(
    .WIDTH_5(5), .WIDTH_32(32), .MD_LAT(4), .EXC_VECTOR(32'h8000_0180)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.RS_D = 5'd0; bus.RT_D = 5'd0; bus.RT_E = 5'd0; bus.WRITE_REG_E = 5'd0;
    bus.MEM_TO_REG_E = 1'b0; bus.REG_WRITE_E = 1'b0; bus.BRANCH_D = 1'b0;
    bus.BRANCH_TAKEN_D = 1'b0; bus.MD_START_D = 1'b0; bus.MFHILO_D = 1'b0;
    bus.EXC_REQ_M = 1'b0; bus.EPC_M = 32'h0;
  endtask

  // inputs already driven; queue the expectation, compare mid-cycle, advance
  task automatic step(input string tag, input logic [6:0] ctrl, input logic [31:0] epc);
    exp_t e;
    logic [6:0] got;
    e.tag = tag; e.ctrl = ctrl; e.epc = epc;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    got = {bus.PC_EN, bus.EN_FD, bus.CLR_FD, bus.CLR_DE, bus.CLR_EM, bus.PC_SEL_EXC, bus.MD_BUSY};
    check({e.tag, ".ctrl"}, {25'd0, got}, {25'd0, e.ctrl});
    check({e.tag, ".epc"}, bus.EPC, e.epc);
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    bus.MEM_TO_REG_E = 1'b1; bus.RT_E = 5'd8; bus.RS_D = 5'd8;
    step("rst_hold", C_N, 32'h0);
    bus.MD_START_D = 1'b1;
    step("rst_hold2", C_N, 32'h0);
    check("exc_pc", bus.EXC_PC, 32'h8000_0180);
`ifdef HAZ_PERF_CNT_EN
    check("stall_cnt_rst", bus.STALL_CNT, 32'd0);
    check("flush_cnt_rst", bus.FLUSH_CNT, 32'd0);
`endif
    rst_n = 1'b1;

    bus.MEM_TO_REG_E = 1'b1; bus.RT_E = 5'd8; bus.RS_D = 5'd8;
    step("lw_rs", C_S, 32'h0);
    step("lw_release", C_N, 32'h0);
    bus.MEM_TO_REG_E = 1'b1; bus.RT_E = 5'd5; bus.RT_D = 5'd5; bus.RS_D = 5'd7;
    step("lw_rt", C_S, 32'h0);
    bus.MEM_TO_REG_E = 1'b1; bus.RT_E = 5'd0; bus.RS_D = 5'd0;
    step("lw_zero", C_N, 32'h0);
    bus.MEM_TO_REG_E = 1'b1; bus.RT_E = 5'd4; bus.RS_D = 5'd6; bus.RT_D = 5'd7;
    step("lw_nomatch", C_N, 32'h0);

    bus.BRANCH_D = 1'b1; bus.BRANCH_TAKEN_D = 1'b1;
    step("br_taken", C_B, 32'h0);
    step("br_after", C_N, 32'h0);
    bus.BRANCH_D = 1'b1; bus.BRANCH_TAKEN_D = 1'b1; bus.REG_WRITE_E = 1'b1;
    bus.WRITE_REG_E = 5'd9; bus.RS_D = 5'd9;
    step("br_haz", C_S, 32'h0);
    bus.BRANCH_D = 1'b1; bus.BRANCH_TAKEN_D = 1'b1; bus.RS_D = 5'd9;
    step("br_retry", C_B, 32'h0);
    bus.BRANCH_D = 1'b1; bus.REG_WRITE_E = 1'b1; bus.WRITE_REG_E = 5'd0; bus.RS_D = 5'd0;
    step("br_zero_nt", C_N, 32'h0);
    bus.REG_WRITE_E = 1'b1; bus.WRITE_REG_E = 5'd9; bus.RS_D = 5'd9;
    step("nobr_regwr", C_N, 32'h0);

    bus.MD_START_D = 1'b1;
    step("md_t0", C_N, 32'h0);
    step("md_t1", C_NB, 32'h0);
    for (int i = 2; i <= 4; i++) begin
      bus.MFHILO_D = 1'b1;
      step($sformatf("md_t%0d_mf", i), C_SB, 32'h0);
    end
    bus.MFHILO_D = 1'b1;
    step("md_t5_issue", C_N, 32'h0);
    step("md_t6", C_N, 32'h0);

    bus.MEM_TO_REG_E = 1'b1; bus.RT_E = 5'd3; bus.RS_D = 5'd3; bus.MD_START_D = 1'b1;
    step("md_lw_block", C_S, 32'h0);
    bus.MD_START_D = 1'b1;
    step("md_issue", C_N, 32'h0);
    step("md_busy", C_NB, 32'h0);
    bus.EXC_REQ_M = 1'b1; bus.EPC_M = 32'h0040_0010;
    step("exc_mdwait", C_XB, 32'h0);
    bus.EXC_REQ_M = 1'b1; bus.EPC_M = 32'hdead_beef;
    step("exc_drain_ign", C_N, 32'h0040_0010);
    step("exc_after", C_N, 32'h0040_0010);

    bus.EXC_REQ_M = 1'b1; bus.EPC_M = 32'h0040_0020;
    bus.MEM_TO_REG_E = 1'b1; bus.RT_E = 5'd2; bus.RS_D = 5'd2;
    bus.BRANCH_D = 1'b1; bus.BRANCH_TAKEN_D = 1'b1;
    step("exc_beats_all", C_X, 32'h0040_0010);
    bus.MD_START_D = 1'b1;
    step("drain_md_start", C_N, 32'h0040_0020);
    step("drain_no_md", C_N, 32'h0040_0020);

    bus.MD_START_D = 1'b1;
    step("md2_issue", C_N, 32'h0040_0020);
    step("md2_busy", C_NB, 32'h0040_0020);
    rst_n = 1'b0;
    step("md2_rst", C_N, 32'h0040_0020);
    rst_n = 1'b1;
    step("post_rst", C_N, 32'h0);
`ifdef HAZ_PERF_CNT_EN
    check("stall_cnt_rst2", bus.STALL_CNT, 32'd0);
    check("flush_cnt_rst2", bus.FLUSH_CNT, 32'd0);
`endif
    step("post_rst2", C_N, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
